mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative HI/LO multiply/divide unit for the MIPS datapath. It sits directly downstream of the register file, consuming `read_data1` (rs) and `read_data2` (rt), and executes MULT, MULTU, DIV and DIVU over multiple cycles. It also services the MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO. Control stalls the PC while `busy` is high.

## Interface
- `WIDTH`, default 32: operand and HI/LO width.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  00 = MULT, 01 = MULTU, 10 = DIV, 11 = DIVU; sampled with `start`.
- `operand_a`  in  WIDTH  rs value (multiplicand or dividend).
- `operand_b`  in  WIDTH  rt value (multiplier or divisor).
- `write_hi`  in  1  MTHI strobe.
- `write_lo`  in  1  MTLO strobe.
- `write_data`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; HI/LO updated in this cycle.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, state IDLE.
- States:
  - IDLE → PREP on `start`.
  - PREP → CALC after 1 cycle.
  - CALC → FIX after 32 iterations, tracked by a 5-bit counter.
  - FIX → IDLE after 1 cycle.
- PREP:
  - Latch operands.
  - Signed ops: take magnitudes and record result signs.
  - Quotient/product sign = a[31] ^ b[31]; remainder sign = a[31].
- CALC, multiply: radix-2 shift-add into a 64-bit accumulator.
- CALC, divide: restoring division using a 33-bit subtractor. Quotient goes to `lo`, remainder to `hi`.
- FIX:
  - Negate results according to the recorded signs.
  - Commit to `hi`/`lo`.
  - Assert `done`.
- Divide by zero (`operand_b` = 0), DIV or DIVU: `lo` = 0xFFFFFFFF, `hi` = `operand_a`. Latency is the same as a normal divide.
- DIV 0x80000000 / 0xFFFFFFFF: `lo` = 0x80000000, `hi` = 0. This is the wrap result; no trap is raised.
- `start` while not in IDLE is ignored.
- `write_hi`/`write_lo` are honored only in IDLE and ignored while busy.
- `write_hi` and `write_lo` in the same cycle both load `write_data`.
- `start` and a write in the same IDLE cycle:
  - The write is applied at that edge.
  - The operation starts.
  - The operation's result overwrites HI/LO at FIX.
- All arithmetic is modulo 2^WIDTH per half. Unsigned ops never negate.

## Timing
- Rising edge E0 with `start` = 1 in IDLE:
  - `busy` = 1 from after E0 through E34.
  - `busy` falls after E34.
  - PREP covers E0 to E1. CALC covers E1 to E33. FIX covers E33 to E34.
- `hi`/`lo` take their new values after E34, and `done` is high for exactly the cycle following E34.
- Fixed latency is 34 cycles for every op, with no early termination.
- Back-to-back operations: `start` can be accepted at E35, in the first IDLE cycle after `done` rises.
- `write_hi`/`write_lo` in IDLE: the register updates at the next edge, with no read-during-write bypass.
- Deassertion of `reset_n` mid-operation: immediate (asynchronous) return to reset values. The partial result is discarded.

## Structure
- Shared package `mips_pkg` holds:
  - the op encodings `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`;
  - the state enum `md_state_t` (IDLE, PREP, CALC, FIX);
  - `MD_ITER = 32`.
- This is a single module with no sub-module. One shared 33-bit adder/subtractor serves both multiply and divide. Negation in PREP and FIX reuses the same two's-complement logic as a local function.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after E34, `hi` = 0xFFFFFFFE and `lo` = 0x00000001; `done` is high for exactly 1 cycle; `busy` is high for exactly 34 cycles.
- MULT 0xFFFFFFFD (−3) × 5 → `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFF1.
- Divide cases:
  - DIV 0xFFFFFFF9 (−7) / 2 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
  - DIVU 7 / 2 → `lo` = 3, `hi` = 1.
- Special divides:
  - DIV 0x1234 / 0 → `lo` = 0xFFFFFFFF, `hi` = 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0.
- Ignored inputs and reset during an operation:
  - Pulse `start` with new operands at E5 → ignored; the original result is unchanged.
  - `write_hi` with 0xAAAA at E10 → ignored.
  - `reset_n` low mid-CALC at E20 → `busy`, `hi`, `lo` are 0 immediately, and no `done` pulse follows.
- IDLE write: `write_lo` = 1 with 0xDEADBEEF → `lo` = 0xDEADBEEF after the next edge; `hi` is unchanged; `busy` stays 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: multiply/divide op encodings, unit states
// and iteration count.
package mips_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    CALC,
    FIX
  } md_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: fixed 34-cycle MULT/MULTU/DIV/DIVU
// over one shared (WIDTH+1)-bit adder, plus MTHI/MTLO writes while idle.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             write_hi,
  input  logic             write_lo,
  input  logic [WIDTH-1:0] write_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(MD_ITER);

  md_state_t        state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_qp_q, neg_qp_d;
  logic             neg_r_q, neg_r_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             is_div, is_signed;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   add_x, add_y, sum;
  logic             add_ci;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  function automatic logic [2*WIDTH-1:0] twos_neg(input logic [2*WIDTH-1:0] x);
    return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    logic [2*WIDTH-1:0] t;
    t = twos_neg({{WIDTH{1'b0}}, x});
    return t[WIDTH-1:0];
  endfunction

  always_comb begin
    is_div    = (op_q == MD_DIV) || (op_q == MD_DIVU);
    is_signed = (op_q == MD_MULT) || (op_q == MD_DIV);
    mag_a     = (is_signed && a_q[WIDTH-1]) ? neg_w(a_q) : a_q;
    mag_b     = (is_signed && b_q[WIDTH-1]) ? neg_w(b_q) : b_q;

    // Multiply: conditional add of multiplicand into HI. Divide: trial
    // subtract of divisor from the remainder shifted left by one bit.
    add_x  = is_div ? {acc_hi_q, acc_lo_q[WIDTH-1]} : {1'b0, acc_hi_q};
    add_y  = is_div ? ~{1'b0, opnd_q} : (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    add_ci = is_div;
    sum    = add_x + add_y + {{WIDTH{1'b0}}, add_ci};

    prod_fix = neg_qp_q ? twos_neg({acc_hi_q, acc_lo_q}) : {acc_hi_q, acc_lo_q};
    quo_fix  = neg_qp_q ? neg_w(acc_lo_q) : acc_lo_q;
    rem_fix  = neg_r_q  ? neg_w(acc_hi_q) : acc_hi_q;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    opnd_d   = opnd_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    neg_qp_d = neg_qp_q;
    neg_r_d  = neg_r_q;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (write_hi) hi_d = write_data;
        if (write_lo) lo_d = write_data;
        if (start) begin
          op_d    = op;
          a_d     = operand_a;
          b_d     = operand_b;
          state_d = PREP;
        end
      end
      PREP: begin
        neg_qp_d = is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_r_d  = is_signed && a_q[WIDTH-1];
        dbz_d    = is_div && (b_q == '0);
        acc_hi_d = '0;
        acc_lo_d = is_div ? mag_a : mag_b;
        opnd_d   = is_div ? mag_b : mag_a;
        cnt_d    = '0;
        state_d  = CALC;
      end
      CALC: begin
        if (is_div) begin
          acc_hi_d = sum[WIDTH] ? add_x[WIDTH-1:0] : sum[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], ~sum[WIDTH]};
        end else begin
          acc_hi_d = sum[WIDTH:1];
          acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MD_ITER - 1)) state_d = FIX;
      end
      FIX: begin
        if (dbz_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else if (is_div) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      neg_qp_q <= 1'b0;
      neg_r_q  <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opnd_q   <= opnd_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
      neg_qp_q <= neg_qp_d;
      neg_r_q  <= neg_r_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed ops push expected HI/LO, a
// monitor pops and compares on every done pulse.
module tb_mult_div_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b, write_data;
  logic        write_hi, write_lo;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  logic        done_prev = 1'b0;
  logic [63:0] exp_q[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .write_hi  (write_hi),
    .write_lo  (write_lo),
    .write_data(write_data),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        check("done_width", 32'(done_prev), 32'h0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL done_unexpected: got done=1 required no pending result");
        end else begin
          e = exp_q.pop_front();
          check("result_hi", hi, e[63:32]);
          check("result_lo", lo, e[31:0]);
        end
      end
      done_prev = done;
    end
  end

  // mode: 0 plain, 1 ignored start/write while busy, 2 write with start, 3 reset mid-CALC
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi,
                        input logic [31:0] elo, input int mode);
    int busy_cycles;
    int dc0;
    logic [31:0] hi_before;
    busy_cycles = 0;
    hi_before   = model_hi;
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    if (mode == 2) begin write_hi = 1'b1; write_data = 32'h1111; end
    if (mode != 3) exp_q.push_back({ehi, elo});
    dc0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0; write_hi = 1'b0;
    if (mode == 2) check({tag, "_write_with_start"}, hi, 32'h1111);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (mode == 1) begin
        if (n == 5) begin start = 1'b1; op = MD_MULTU; operand_a = '1; operand_b = '1; end
        if (n == 6) start = 1'b0;
        if (n == 10) begin write_hi = 1'b1; write_data = 32'hAAAA; end
        if (n == 11) begin
          write_hi = 1'b0;
          check({tag, "_busy_write_ignored"}, hi, hi_before);
        end
      end
      if (mode == 3 && n == 20) begin
        reset_n = 1'b0;
        #1;
        check({tag, "_rst_busy"}, 32'(busy), 32'h0);
        check({tag, "_rst_hi"}, hi, 32'h0);
        check({tag, "_rst_lo"}, lo, 32'h0);
        model_hi = '0;
        model_lo = '0;
        return;
      end
      if (!busy) break;
      busy_cycles++;
    end
    check({tag, "_busy_len"}, busy_cycles, 32'd34);
    #1;
    check({tag, "_done_pulses"}, done_cnt, dc0 + 1);
    model_hi = ehi;
    model_lo = elo;
  endtask

  initial begin
    int dc_rst;
    reset_n = 1'b0; start = 1'b0; op = '0; operand_a = '0; operand_b = '0;
    write_hi = 1'b0; write_lo = 1'b0; write_data = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    run_op("mult_neg3x5", MD_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    run_op("mult_minmax", MD_MULT, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 0);
    run_op("div_neg7_2", MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op("div_neg7_neg2", MD_DIV, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 0);
    run_op("div_100_7", MD_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 0);
    run_op("divu_7_2", MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 0);
    run_op("divu_big_2", MD_DIVU, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC, 0);
    run_op("div_by_zero", MD_DIV, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 0);
    run_op("divu_by_zero", MD_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 0);
    run_op("div_wrap", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0);
    run_op("div_negzero", MD_DIV, 32'hFFFFFF00, 32'd0, 32'hFFFFFF00, 32'hFFFFFFFF, 0);
    run_op("ignored_inputs", MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1);
    run_op("start_and_write", MD_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 2);

    dc_rst = done_cnt;
    run_op("reset_mid_calc", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 3);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_reset_no_done", done_cnt, dc_rst);
    check("post_reset_busy", 32'(busy), 32'h0);
    check("post_reset_hi", hi, model_hi);
    check("post_reset_lo", lo, model_lo);

    write_lo = 1'b1; write_data = 32'hDEADBEEF;
    #1;
    check("mtlo_no_bypass", lo, model_lo);
    @(negedge clk);
    write_lo = 1'b0;
    check("mtlo_lo", lo, 32'hDEADBEEF);
    check("mtlo_hi_kept", hi, model_hi);
    check("mtlo_busy", 32'(busy), 32'h0);
    write_hi = 1'b1; write_lo = 1'b1; write_data = 32'h5A5A5A5A;
    @(negedge clk);
    write_hi = 1'b0; write_lo = 1'b0;
    check("mthi_mtlo_hi", hi, 32'h5A5A5A5A);
    check("mthi_mtlo_lo", lo, 32'h5A5A5A5A);

    repeat (2) @(negedge clk);
    check("pending_results", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
